// File: rtl/store_output_unit_pkg.sv
// Shared DMA write-path constants, FSM state encoding and control-word packing
// for the store output unit and its sibling input loader.
package store_output_unit_pkg;

   localparam int DMA_SIZE_W = 3;
   localparam int DMA_LEN_W  = 32;
   localparam int DMA_IDX_W  = 32;
   localparam int DMA_CTRL_W = DMA_SIZE_W + DMA_LEN_W + DMA_IDX_W;
   localparam int CONF_W     = 96;

   localparam logic [DMA_SIZE_W-1:0] DMA_SIZE_WORD = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SND_WR_REQ = 2'd1,
      ST_STREAM     = 2'd2,
      ST_DONE       = 2'd3
   } xfer_state_e;

   typedef struct packed {
      logic [DMA_SIZE_W-1:0] size;
      logic [DMA_LEN_W-1:0]  length;
      logic [DMA_IDX_W-1:0]  index;
   } dma_ctrl_t;

   function automatic logic [DMA_CTRL_W-1:0] pack_dma_ctrl(
      input logic [DMA_LEN_W-1:0] length,
      input logic [DMA_IDX_W-1:0] index
   );
      dma_ctrl_t ctrl;
      ctrl.size   = DMA_SIZE_WORD;
      ctrl.length = length;
      ctrl.index  = index;
      return ctrl;
   endfunction

endpackage

// File: rtl/store_output_unit_if.sv
// DMA write ctrl/chnl handshakes plus the output-BRAM read port, seen from the
// store unit (master) and from the DMA/memory side (slave).
interface store_output_unit_if #(
   parameter int DMA_DATA_WIDTH = 32,
   parameter int MEM_ADDR_W     = 6
);
   import store_output_unit_pkg::*;

   logic                      write_ctrl_valid;
   logic                      write_ctrl_ready;
   logic [DMA_CTRL_W-1:0]     write_ctrl_data;
   logic                      write_chnl_valid;
   logic                      write_chnl_ready;
   logic [DMA_DATA_WIDTH-1:0] write_chnl_data;
   logic                      mem_rd_en;
   logic [MEM_ADDR_W-1:0]     mem_addr;
   logic [DMA_DATA_WIDTH-1:0] mem_rd_data;

   modport master (
      output write_ctrl_valid, write_ctrl_data,
      output write_chnl_valid, write_chnl_data,
      output mem_rd_en, mem_addr,
      input  write_ctrl_ready, write_chnl_ready, mem_rd_data
   );

   modport slave (
      input  write_ctrl_valid, write_ctrl_data,
      input  write_chnl_valid, write_chnl_data,
      input  mem_rd_en, mem_addr,
      output write_ctrl_ready, write_chnl_ready, mem_rd_data
   );

endinterface

// File: rtl/store_output_unit_sync_fifo.sv
// Small synchronous FIFO decoupling BRAM read returns from DMA beat acceptance.
// No bypass: a pushed word becomes visible at the head one cycle later.
module store_output_unit_sync_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 32,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_s;
   logic             pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return ptr + PTR_W'(1'b1);
      end
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign push_s  = push_i && !full_o;
   assign pop_s   = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = push_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1'b1);
         2'b01:   count_d = count_q - CNT_W'(1'b1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/store_output_unit.sv
// Streams result words from the two interleaved output BRAMs to main memory:
// one DMA write request, then a prefetch-FIFO decoupled read/send stream.
module store_output_unit
   import store_output_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 5,
   parameter int BRAM_INDEX     = 1,
   parameter int DMA_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_store,
   output logic                storing,
   output logic                store_done,
   input  logic [CONF_W-1:0]   conf_regs,
   store_output_unit_if.master wr_if
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   xfer_state_e               state_q, state_d;
   logic [DMA_LEN_W-1:0]      len_q, len_d;
   logic [DMA_IDX_W-1:0]      idx_q, idx_d;
   logic [DMA_LEN_W-1:0]      issued_q, issued_d;
   logic [DMA_LEN_W-1:0]      sent_q, sent_d;
   logic [BRAM_INDEX-1:0]     bram_idx_q, bram_idx_d;
   logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
   logic                      inflight_q, inflight_d;

   logic                      issue_s;
   logic                      pop_s;
   logic                      chnl_valid_s;
   logic                      ctrl_valid_s;
   logic [OCC_W-1:0]          occupancy_s;
   logic [DMA_DATA_WIDTH-1:0] fifo_head_s;
   logic                      fifo_empty_s;
   logic                      fifo_full_unused_s;
   logic [CNT_W-1:0]          fifo_count_s;
   logic [31:0]               conf_unused_s;

   assign conf_unused_s = conf_regs[95:64];

   store_output_unit_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DMA_DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .pop_i   (pop_s),
      .data_i  (wr_if.mem_rd_data),
      .data_o  (fifo_head_s),
      .full_o  (fifo_full_unused_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   // A read may issue only if its word is guaranteed a FIFO slot when it returns.
   assign occupancy_s  = {1'b0, fifo_count_s} + OCC_W'(inflight_q) - OCC_W'(pop_s);
   assign issue_s      = (state_q == ST_STREAM) && (issued_q < len_q) &&
                         (occupancy_s < OCC_W'(FIFO_DEPTH));
   assign chnl_valid_s = (state_q == ST_STREAM) && !fifo_empty_s;
   assign pop_s        = chnl_valid_s && wr_if.write_chnl_ready;
   assign ctrl_valid_s = (state_q == ST_SND_WR_REQ);

   assign storing                = (state_q == ST_SND_WR_REQ) || (state_q == ST_STREAM);
   assign store_done             = (state_q == ST_DONE);
   assign wr_if.write_ctrl_valid = ctrl_valid_s;
   assign wr_if.write_ctrl_data  = ctrl_valid_s ? pack_dma_ctrl(len_q, idx_q) : '0;
   assign wr_if.write_chnl_valid = chnl_valid_s;
   assign wr_if.write_chnl_data  = chnl_valid_s ? fifo_head_s : '0;
   assign wr_if.mem_rd_en        = issue_s;
   assign wr_if.mem_addr         = issue_s ? {bram_idx_q, rd_addr_q} : '0;

   // Next-state logic for the transfer FSM, counters and interleaved read address.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      issued_d   = issued_q;
      sent_d     = sent_q;
      bram_idx_d = bram_idx_q;
      rd_addr_d  = rd_addr_q;
      inflight_d = issue_s;

      case (state_q)
         ST_IDLE: begin
            if (start_store) begin
               len_d      = conf_regs[31:0];
               idx_d      = conf_regs[63:32];
               issued_d   = '0;
               sent_d     = '0;
               bram_idx_d = '0;
               rd_addr_d  = '0;
               state_d    = (conf_regs[31:0] == 32'd0) ? ST_DONE : ST_SND_WR_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SND_WR_REQ: begin
            if (wr_if.write_ctrl_ready) begin
               state_d = ST_STREAM;
            end else begin
               state_d = ST_SND_WR_REQ;
            end
         end

         ST_STREAM: begin
            if (issue_s) begin
               issued_d   = issued_q + 32'd1;
               bram_idx_d = bram_idx_q + BRAM_INDEX'(1'b1);
               // Both BRAMs have been read at this address; move to the next row.
               if (bram_idx_q == {BRAM_INDEX{1'b1}}) begin
                  rd_addr_d = rd_addr_q + ADDR_WIDTH'(1'b1);
               end else begin
                  rd_addr_d = rd_addr_q;
               end
            end else begin
               issued_d = issued_q;
            end

            if (pop_s) begin
               sent_d = sent_q + 32'd1;
               if ((sent_q + 32'd1) == len_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_STREAM;
               end
            end else begin
               sent_d = sent_q;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transfer without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         bram_idx_q <= '0;
         rd_addr_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         issued_q   <= issued_d;
         sent_q     <= sent_d;
         bram_idx_q <= bram_idx_d;
         rd_addr_q  <= rd_addr_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_store_output_unit.sv
// Scoreboard bench for store_output_unit: expected addresses/beats are queued at
// start and consumed by a negedge monitor; a BRAM model answers reads.
module tb_store_output_unit;
   import store_output_unit_pkg::*;

   localparam int AW = 5;
   localparam int BI = 1;
   localparam int DW = 32;
   localparam int FD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_store;
   logic        storing;
   logic        store_done;
   logic [95:0] conf_regs;

   store_output_unit_if #(.DMA_DATA_WIDTH(DW), .MEM_ADDR_W(AW + BI)) bus ();

   store_output_unit #(
      .ADDR_WIDTH     (AW),
      .BRAM_INDEX     (BI),
      .DMA_DATA_WIDTH (DW),
      .FIFO_DEPTH     (FD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_store (start_store),
      .storing     (storing),
      .store_done  (store_done),
      .conf_regs   (conf_regs),
      .wr_if       (bus.master)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] exp_data_q [$];
   logic [5:0]  exp_addr_q [$];
   logic [66:0] exp_ctrl;
   logic [31:0] exp_len;
   bit          req_expected;
   bit          ctrl_fired;
   int          start_cyc;
   int          last_beat_cyc;
   int          beats_seen;
   int          done_count;
   int          chnl_mode;
   int          ctrl_stall_left;
   logic [7:0]  run_tag;

   function automatic logic [31:0] bram_word(input logic [7:0] tag, input logic [5:0] addr);
      return {tag, 18'h0, addr};
   endfunction

   task automatic check_value(input string tag, input logic [66:0] act, input logic [66:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= bram_word(run_tag, bus.mem_addr);
   end

   // Handshake drivers, applied 2 time units after the edge
   initial begin
      bus.write_ctrl_ready = 1'b1;
      bus.write_chnl_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (chnl_mode == 1) bus.write_chnl_ready = ~bus.write_chnl_ready;
         else                bus.write_chnl_ready = 1'b1;
         if (ctrl_stall_left > 0) begin
            bus.write_ctrl_ready = 1'b0;
            ctrl_stall_left--;
         end else begin
            bus.write_ctrl_ready = 1'b1;
         end
      end
   end

   // Monitor: consumes scoreboard entries at each negedge
   initial begin
      bit          prev_ctrl_stall = 1'b0;
      bit          prev_chnl_stall = 1'b0;
      logic [66:0] prev_ctrl_data = '0;
      logic [31:0] prev_chnl_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ctrl_stall = 1'b0;
            prev_chnl_stall = 1'b0;
         end else begin
            if (bus.mem_rd_en) begin
               if (!ctrl_fired)                 check_value("rd_before_fire", 1'b1, 1'b0);
               else if (exp_addr_q.size() == 0) check_value("rd_extra", 1'b1, 1'b0);
               else                             check_value("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
            end
            if (prev_ctrl_stall) begin
               check_value("ctrl_valid_held", bus.write_ctrl_valid, 1'b1);
               check_value("ctrl_stable", bus.write_ctrl_data, prev_ctrl_data);
            end
            if (bus.write_ctrl_valid && bus.write_ctrl_ready) begin
               if (!req_expected) check_value("ctrl_unexpected", 1'b1, 1'b0);
               else               check_value("ctrl_data", bus.write_ctrl_data, exp_ctrl);
               ctrl_fired   = 1'b1;
               req_expected = 1'b0;
            end
            prev_ctrl_stall = bus.write_ctrl_valid && !bus.write_ctrl_ready;
            prev_ctrl_data  = bus.write_ctrl_data;

            if (prev_chnl_stall) begin
               check_value("chnl_valid_held", bus.write_chnl_valid, 1'b1);
               check_value("chnl_stable", bus.write_chnl_data, prev_chnl_data);
            end
            if (bus.write_chnl_valid && bus.write_chnl_ready) begin
               if (exp_data_q.size() == 0) check_value("beat_extra", 1'b1, 1'b0);
               else                        check_value("beat_data", bus.write_chnl_data, exp_data_q.pop_front());
               beats_seen++;
               last_beat_cyc = cyc;
            end
            prev_chnl_stall = bus.write_chnl_valid && !bus.write_chnl_ready;
            prev_chnl_data  = bus.write_chnl_data;

            if (store_done) begin
               done_count++;
               check_value("storing_at_done", storing, 1'b0);
               if (exp_len == 32'd0) check_value("done_lat_len0", cyc, start_cyc + 1);
               else                  check_value("done_lat", cyc, last_beat_cyc + 1);
            end
         end
      end
   end

   task automatic start_run(input logic [31:0] len, input logic [31:0] idx,
                            input int mode, input int ctrl_stall);
      logic [5:0] a;
      @(posedge clk);
      #1;
      run_tag         = run_tag + 8'd1;
      chnl_mode       = mode;
      ctrl_stall_left = ctrl_stall;
      exp_len         = len;
      exp_ctrl        = {DMA_SIZE_WORD, len, idx};
      req_expected    = (len != 32'd0);
      ctrl_fired      = 1'b0;
      done_count      = 0;
      beats_seen      = 0;
      for (int i = 0; i < int'(len); i++) begin
         a = {i[0], 5'(i >> 1)};
         exp_addr_q.push_back(a);
         exp_data_q.push_back(bram_word(run_tag, a));
      end
      conf_regs   = {32'hDEAD_BEEF, idx, len};
      start_store = 1'b1;
      start_cyc   = cyc;
      @(posedge clk);
      #1;
      start_store = 1'b0;
      conf_regs   = {32'h0, 32'hFFFF_FFFF, 32'd5};
      @(negedge clk);
      check_value("storing_after_start", storing, len != 32'd0);
   endtask

   task automatic finish_run(input logic [31:0] len);
      int n = 0;
      while (done_count == 0 && n < 4 * int'(len) + 60) begin
         @(posedge clk);
         n++;
      end
      if (done_count == 0) check_value("done_timeout", 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      check_value("done_once", done_count, 1);
      check_value("beats_left", exp_data_q.size(), 0);
      check_value("addr_left", exp_addr_q.size(), 0);
      check_value("beat_count", beats_seen, len);
      check_value("req_pending", req_expected, 1'b0);
   endtask

   task automatic run_store(input logic [31:0] len, input logic [31:0] idx,
                            input int mode, input int ctrl_stall);
      start_run(len, idx, mode, ctrl_stall);
      finish_run(len);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_value(tag, {storing, store_done, bus.write_ctrl_valid, bus.write_chnl_valid,
                        bus.write_chnl_data, bus.mem_rd_en, bus.mem_addr}, 67'd0);
      check_value({tag, "_ctrl"}, bus.write_ctrl_data, 67'd0);
   endtask

   initial begin
      int n;
      rst             = 1'b1;
      start_store     = 1'b0;
      conf_regs       = 96'd0;
      chnl_mode       = 0;
      ctrl_stall_left = 0;
      run_tag         = 8'd0;
      req_expected    = 1'b0;
      ctrl_fired      = 1'b0;
      exp_len         = 32'd0;
      done_count      = 0;
      beats_seen      = 0;
      last_beat_cyc   = 0;
      start_cyc       = 0;
      exp_ctrl        = 67'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_store(32'd4, 32'h100, 0, 0);
      run_store(32'd8, 32'h2000, 1, 0);
      run_store(32'd0, 32'h40, 0, 0);
      run_store(32'd5, 32'h77, 0, 11);

      // Abort mid-stream, then a fresh transfer must restart at {0,0}
      start_run(32'd8, 32'h300, 0, 0);
      n = 0;
      while (beats_seen < 3 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (beats_seen < 3) check_value("abort_wait_timeout", 1'b0, 1'b1);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero("abort_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_data_q.delete();
      exp_addr_q.delete();
      repeat (5) @(posedge clk);
      check_value("abort_no_done", done_count, 0);
      run_store(32'd4, 32'h100, 0, 0);

      run_store(32'd70, 32'h1234, 0, 0);
      run_store(32'd70, 32'h5678, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
